// File: rtl/my_pkg.sv
// my_pkg: instruction classes, holding-register states and the field-map decode shared by the issue controller.
package my_pkg;
  typedef enum logic [1:0] {CLS_NOP, CLS_LDBR, CLS_REG, CLS_LIT} cls_t;
  typedef enum logic {S_EMPTY, S_HELD} state_t;
  localparam logic [5:0] OP_ST = 6'h19;
  typedef struct packed {
    logic [4:0] rd_a;
    logic       rd_a_v;
    logic [4:0] rd_b;
    logic       rd_b_v;
    logic [4:0] wr;
    logic       wr_v;
  } dec_t;
  // R31 is filtered here so nothing downstream ever treats it as a hazard or tracks it
  function automatic dec_t decode(input logic [31:11] instr);
    cls_t cls;
    logic st;
    dec_t d;
    cls = cls_t'(instr[31:30]);
    st = instr[31:26] == OP_ST;
    d.rd_a = instr[25:21];
    d.rd_b = instr[20:16];
    d.wr = cls == CLS_REG ? instr[15:11] : cls == CLS_LIT ? instr[20:16] : instr[25:21];
    d.rd_a_v = (st || cls == CLS_REG || cls == CLS_LIT) && d.rd_a != 5'd31;
    d.rd_b_v = (cls == CLS_LDBR || cls == CLS_REG) && d.rd_b != 5'd31;
    d.wr_v = ((cls == CLS_LDBR && !st) || cls == CLS_REG || cls == CLS_LIT) && d.wr != 5'd31;
    return d;
  endfunction
endpackage

// File: rtl/beta_scoreboard.sv
// beta_scoreboard: pending-write vector and outstanding-write counter with set on issue and clear on writeback.
module beta_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_reg,
  input  logic        clr_en,
  input  logic [4:0]  clr_reg,
  output logic [31:0] pending,
  output logic [3:0]  inflight
);
  logic clr_hit;
  // a set register is never already pending, so set and clear never collide
  assign clr_hit = clr_en && clr_reg != 5'd31 && pending[clr_reg];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      inflight <= '0;
    end else begin
      pending <= (pending | (32'(set_en) << set_reg)) & ~(32'(clr_hit) << clr_reg);
      inflight <= inflight + 4'(set_en) - 4'(clr_hit);
    end
endmodule

// File: rtl/beta_issue_ctrl.sv
// beta_issue_ctrl: one-deep issue buffer that releases an instruction to the Beta core once it is free of RAW/WAW hazards.
module beta_issue_ctrl
  import my_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  logic [31:0]        IN_INSTR,
  output logic               IN_READY,
  output logic               ISSUE_VALID,
  output logic [31:0]        ISSUE_INSTR,
  input  logic               ISSUE_READY,
  input  logic               WB_VALID,
  input  logic [4:0]         WB_REG,
  input  logic               FLUSH,
  output logic [31:0]        PENDING,
  output logic [3:0]         INFLIGHT,
  output logic [STALL_W-1:0] STALL_CYCLES
);
  localparam logic [3:0] MAX_I = 4'(MAX_INFLIGHT);
  state_t state;
  dec_t d;
  logic hazard, fire;
  assign d = decode(ISSUE_INSTR[31:11]);
  // registered PENDING only: a writeback unblocks a consumer one cycle later
  assign hazard = (d.rd_a_v && PENDING[d.rd_a]) || (d.rd_b_v && PENDING[d.rd_b]) ||
                  (d.wr_v && (PENDING[d.wr] || INFLIGHT == MAX_I));
  assign ISSUE_VALID = state == S_HELD && !hazard && !FLUSH;
  assign fire = ISSUE_VALID && ISSUE_READY;
  assign IN_READY = !FLUSH && (state == S_EMPTY || fire);
  beta_scoreboard u_sb (
    .clk(CLK),
    .rst(RST),
    .set_en(fire && d.wr_v),
    .set_reg(d.wr),
    .clr_en(WB_VALID),
    .clr_reg(WB_REG),
    .pending(PENDING),
    .inflight(INFLIGHT)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_EMPTY;
      ISSUE_INSTR <= '0;
      STALL_CYCLES <= '0;
    end else begin
      if (IN_VALID && IN_READY) begin
        state <= S_HELD;
        ISSUE_INSTR <= IN_INSTR;
      end else if (fire || FLUSH) state <= S_EMPTY;
      if (state == S_HELD && hazard && !(&STALL_CYCLES)) STALL_CYCLES <= STALL_CYCLES + STALL_W'(1);
    end
endmodule

// File: tb/tb_beta_issue_ctrl.sv
// tb_beta_issue_ctrl: directed scenarios plus randomized traffic checked against a register-set reference model.
module tb_beta_issue_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, issue_ready = 0, wb_valid = 0, flush = 0;
  logic [31:0] in_instr = '0;
  logic [4:0] wb_reg = '0;
  logic in_ready, issue_valid;
  logic [31:0] issue_instr, pending;
  logic [3:0] inflight;
  logic [15:0] stall_cycles;
  int n_tests = 0, n_fail = 0;
  bit [31:0] m_pend;
  bit m_held;
  logic [31:0] m_instr;
  int m_stall;

  beta_issue_ctrl #(.MAX_INFLIGHT(4), .STALL_W(16)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_INSTR(in_instr), .IN_READY(in_ready),
    .ISSUE_VALID(issue_valid), .ISSUE_INSTR(issue_instr), .ISSUE_READY(issue_ready),
    .WB_VALID(wb_valid), .WB_REG(wb_reg), .FLUSH(flush), .PENDING(pending),
    .INFLIGHT(inflight), .STALL_CYCLES(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] lit(input int rc, input int ra);
    return {2'b11, 4'b0, 5'(ra), 5'(rc), 16'h0};
  endfunction

  function automatic logic [31:0] rop(input int rc, input int ra, input int rb);
    return {2'b10, 4'b0, 5'(ra), 5'(rb), 5'(rc), 11'h0};
  endfunction

  // registers read (ra, rb) and written (w) by an instruction; -1 means none
  function automatic void mdec(input logic [31:0] i, output int ra, output int rb, output int w);
    ra = -1; rb = -1; w = -1;
    case (i[31:30])
      2'b01: if (i[31:26] == 6'h19) begin ra = int'(i[25:21]); rb = int'(i[20:16]); end
             else begin w = int'(i[25:21]); rb = int'(i[20:16]); end
      2'b10: begin ra = int'(i[25:21]); rb = int'(i[20:16]); w = int'(i[15:11]); end
      2'b11: begin ra = int'(i[25:21]); w = int'(i[20:16]); end
      default: ;
    endcase
    if (ra == 31) ra = -1;
    if (rb == 31) rb = -1;
    if (w == 31) w = -1;
  endfunction

  function automatic bit m_hazard();
    int ra, rb, w;
    mdec(m_instr, ra, rb, w);
    return (ra >= 0 && m_pend[ra]) || (rb >= 0 && m_pend[rb]) ||
           (w >= 0 && (m_pend[w] || $countones(m_pend) == 4));
  endfunction

  function automatic bit m_valid();
    return m_held && !m_hazard() && !flush;
  endfunction

  function automatic bit m_ready();
    return !flush && (!m_held || (m_valid() && issue_ready));
  endfunction

  // advance the model by one clock using the current inputs, then cross the edge
  task automatic tick();
    bit h, f, acc;
    int ra, rb, w;
    h = m_hazard();
    f = m_valid() && issue_ready;
    acc = in_valid && m_ready();
    mdec(m_instr, ra, rb, w);
    if (m_held && h && m_stall < 65535) m_stall++;
    if (wb_valid && wb_reg != 5'd31) m_pend[wb_reg] = 0;
    if (f && w >= 0) m_pend[w] = 1;
    if (acc) begin m_held = 1; m_instr = in_instr; end
    else if (f || flush) m_held = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; issue_ready = 0; wb_valid = 0; flush = 0; in_instr = '0; wb_reg = '0;
    m_pend = '0; m_held = 0; m_instr = '0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    issue_ready = 1; in_valid = 1; in_instr = lit(6, 0);
    tick();
    in_instr = rop(9, 6, 6);
    tick();
    in_valid = 0;
    tick();
    n_tests++;
    if (pending !== 32'h40 || stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL reset_pre: pending=%h stall=%0d exp 00000040/1", pending, stall_cycles);
    end
    #2 rst = 1;
    #1;
    n_tests++;
    if (issue_valid !== 1'b0 || issue_instr !== 32'h0 || pending !== 32'h0 || inflight !== 4'd0 || stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_clear: valid=%b instr=%h pending=%h inflight=%0d stall=%0d exp all 0",
                         issue_valid, issue_instr, pending, inflight, stall_cycles);
    end
    m_pend = '0; m_held = 0; m_instr = '0; m_stall = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b issue_valid=%b exp 1/0", in_ready, issue_valid);
    end
  endtask

  task automatic test_raw();
    do_reset();
    issue_ready = 1; in_valid = 1; in_instr = rop(3, 1, 2);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_accept: in_ready=%b exp 1", in_ready); end
    tick();
    in_instr = rop(4, 3, 3);
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_producer: issue_valid=%b in_ready=%b exp 1/1", issue_valid, in_ready);
    end
    tick();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin wb_valid = 1; wb_reg = 5'd3; end
      @(negedge clk);
      n_tests++;
      if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d: issue_valid=%b exp 0", k, issue_valid); end
      tick();
    end
    wb_valid = 0;
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || stall_cycles !== 16'd3 || issue_instr !== rop(4, 3, 3)) begin
      n_fail++; $display("FAIL raw_release: issue_valid=%b stall=%0d instr=%h exp 1/3/%h",
                         issue_valid, stall_cycles, issue_instr, rop(4, 3, 3));
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pending !== 32'h10 || inflight !== 4'd1) begin
      n_fail++; $display("FAIL raw_after: pending=%h inflight=%0d exp 00000010/1", pending, inflight);
    end
  endtask

  task automatic test_inflight();
    int r;
    do_reset();
    issue_ready = 1; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_instr = lit(k + 1, 0);
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL inflight_feed%0d: in_ready=%b exp 1", k, in_ready); end
      tick();
    end
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (issue_valid !== 1'b0 || inflight !== 4'd4 || pending !== 32'h1E) begin
        n_fail++; $display("FAIL inflight_limit%0d: valid=%b inflight=%0d pending=%h exp 0/4/0000001e",
                           k, issue_valid, inflight, pending);
      end
      tick();
    end
    r = $urandom_range(1, 4);
    wb_valid = 1; wb_reg = 5'(r);
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_wb_same: issue_valid=%b exp 0", issue_valid); end
    tick();
    wb_valid = 0;
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || inflight !== 4'd3) begin
      n_fail++; $display("FAIL inflight_release: valid=%b inflight=%0d exp 1/3", issue_valid, inflight);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pending !== (32'h3E & ~(32'h1 << r)) || inflight !== 4'd4) begin
      n_fail++; $display("FAIL inflight_after: pending=%h inflight=%0d exp %h/4",
                         pending, inflight, 32'h3E & ~(32'h1 << r));
    end
  endtask

  task automatic test_r31();
    do_reset();
    issue_ready = 1; in_valid = 1; in_instr = rop(31, 1, 2);
    tick();
    in_instr = rop(5, 31, 31);
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL r31_write_fire: issue_valid=%b exp 1", issue_valid); end
    tick();
    in_valid = 0;
    @(negedge clk);
    n_tests++;
    if (pending !== 32'h0 || inflight !== 4'd0 || issue_valid !== 1'b1 || stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL r31_reader: pending=%h inflight=%0d valid=%b stall=%0d exp 0/0/1/0",
                         pending, inflight, issue_valid, stall_cycles);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pending !== 32'h20) begin n_fail++; $display("FAIL r31_after: pending=%h exp 00000020", pending); end
  endtask

  task automatic test_wb_same_edge();
    do_reset();
    issue_ready = 1; in_valid = 1; in_instr = lit(2, 0);
    tick();
    in_instr = lit(7, 0);
    tick();
    in_valid = 0; wb_valid = 1; wb_reg = 5'd2;
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b1 || pending !== 32'h4 || inflight !== 4'd1) begin
      n_fail++; $display("FAIL wb_before: valid=%b pending=%h inflight=%0d exp 1/00000004/1", issue_valid, pending, inflight);
    end
    tick();
    wb_reg = 5'd9;
    @(negedge clk);
    n_tests++;
    if (pending !== 32'h80 || inflight !== 4'd1) begin
      n_fail++; $display("FAIL wb_same_edge: pending=%h inflight=%0d exp 00000080/1", pending, inflight);
    end
    tick();
    wb_reg = 5'd31;
    tick();
    wb_valid = 0;
    @(negedge clk);
    n_tests++;
    if (pending !== 32'h80 || inflight !== 4'd1) begin
      n_fail++; $display("FAIL wb_ignored: pending=%h inflight=%0d exp 00000080/1", pending, inflight);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue_ready = 1; in_valid = 1; in_instr = lit(3, 0);
    tick();
    in_instr = rop(4, 3, 0);
    tick();
    in_valid = 0;
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stalled: issue_valid=%b exp 0", issue_valid); end
    tick();
    in_valid = 1; in_instr = lit(10, 0); flush = 1;
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: valid=%b in_ready=%b exp 0/0", issue_valid, in_ready);
    end
    tick();
    flush = 0; in_valid = 0;
    @(negedge clk);
    n_tests++;
    if (issue_valid !== 1'b0 || in_ready !== 1'b1 || pending !== 32'h8 || inflight !== 4'd1) begin
      n_fail++; $display("FAIL flush_after: valid=%b in_ready=%b pending=%h inflight=%0d exp 0/1/00000008/1",
                         issue_valid, in_ready, pending, inflight);
    end
    tick();
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    int cls;
    logic [5:0] op;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cls = $urandom_range(0, 3);
      op = (cls == 1) ? (($urandom_range(0, 2) == 0) ? 6'h19 : 6'h18) : {2'(cls), 4'($urandom)};
      in_instr = {op, 5'(rnd_reg()), 5'(rnd_reg()), 5'(rnd_reg()), 11'($urandom)};
      in_valid = ($urandom_range(0, 2) != 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_reg = 5'(rnd_reg());
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      n_tests++;
      if (issue_valid !== m_valid() || in_ready !== m_ready() || issue_instr !== m_instr) begin
        n_fail++; $display("FAIL rand_hs c%0d: valid=%b ready=%b instr=%h exp %b/%b/%h",
                           c, issue_valid, in_ready, issue_instr, m_valid(), m_ready(), m_instr);
      end
      n_tests++;
      if (pending !== m_pend || inflight !== 4'($countones(m_pend)) || stall_cycles !== 16'(m_stall)) begin
        n_fail++; $display("FAIL rand_sb c%0d: pending=%h inflight=%0d stall=%0d exp %h/%0d/%0d",
                           c, pending, inflight, stall_cycles, m_pend, $countones(m_pend), m_stall);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_inflight();
    test_r31();
    test_wb_same_edge();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/beta_issue_ctrl.md
# beta_issue_ctrl

- Issue controller that sits between the instruction source and the Beta core's INSTR input.
- Holds one instruction at a time, decodes its register reads and writes using the team's field map, and checks them against a 32-entry pending-write scoreboard.
- Releases the instruction to the core only when there is no RAW or WAW hazard and the in-flight limit allows.
- Clears scoreboard entries from a writeback completion port, and counts stall cycles for the bench.

## Interface

Parameters:
- MAX_INFLIGHT, default 4: maximum number of outstanding tracked register writes (1..15).
- STALL_W, default 16: width of the stall-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset; asynchronous, active-high.
- IN_VALID  in  1  the upstream source offers an instruction.
- IN_INSTR  in  32  the offered instruction.
- IN_READY  out  1  the controller accepts IN_INSTR this cycle.
- ISSUE_VALID  out  1  the held instruction is cleared for issue.
- ISSUE_INSTR  out  32  the held instruction.
- ISSUE_READY  in  1  the core takes the instruction this cycle.
- WB_VALID  in  1  a register write has completed.
- WB_REG  in  5  the register whose write completed.
- FLUSH  in  1  drop the held instruction.
- PENDING  out  32  current scoreboard vector.
- INFLIGHT  out  4  number of outstanding tracked writes.
- STALL_CYCLES  out  STALL_W  saturating count of stall cycles.

## Operation

Decode (class = IN_INSTR[31:30]):
- Store (opcode [31:26] == 6'h19): reads [25:21] and [20:16]; no write.
- Other class 01 (load/branch): writes [25:21]; reads [20:16].
- Class 10 (register op): reads [25:21] and [20:16]; writes [15:11].
- Class 11 (literal op): reads [25:21]; writes [20:16].
- Class 00: NOP; no reads, no writes.
- R31 is never a hazard source, and writes to R31 are never tracked.

Hazard and issue:
- hazard = any read register pending, OR write register pending, OR (instruction writes a tracked register AND INFLIGHT == MAX_INFLIGHT).
- Holding register states: EMPTY and HELD.
- EMPTY -> HELD on IN_VALID && IN_READY.
- HELD -> EMPTY on issue fire with no new accept.
- HELD stays HELD on issue fire with a same-cycle accept (back-to-back).
- ISSUE_VALID = HELD && !hazard && !FLUSH.
- fire = ISSUE_VALID && ISSUE_READY.
- IN_READY = !FLUSH && (EMPTY || fire).
- On fire with a tracked write: set PENDING[dest] and increment INFLIGHT.
- WB_VALID with PENDING[WB_REG] = 1: clear the bit and decrement INFLIGHT.
- WB_VALID with a non-pending WB_REG, or WB_REG = 31: ignored.
- Same-edge fire (setting X) and writeback (clearing Y != X): both apply; net INFLIGHT change is 0.
- STALL_CYCLES increments each cycle where HELD && hazard; it saturates at all-ones.
- FLUSH: HELD -> EMPTY; the scoreboard and INFLIGHT are untouched.

## Timing

- Reset values: ISSUE_VALID 0, ISSUE_INSTR 0, PENDING 0, INFLIGHT 0, STALL_CYCLES 0, state EMPTY. IN_READY is 1 once RST deasserts.
- Latency: an instruction accepted at edge N can fire in cycle N+1 at the earliest.
- Hazard evaluation uses the registered PENDING only, with no bypass. A writeback at edge M unblocks a dependent instruction in cycle M+1, not cycle M.
- A consumer issued immediately after its producer fires sees the pending bit and stalls.
- ISSUE_INSTR is stable while HELD and changes only at accept edges.
- ISSUE_VALID may deassert without a fire only because of FLUSH.
- RST asserted mid-operation clears all state immediately; any held instruction is lost.

## Structure

- Shared package my_pkg holds:
  - instruction class enum {CLS_NOP, CLS_LDBR, CLS_REG, CLS_LIT};
  - constant OP_ST = 6'h19;
  - a decode function returning rd_a, rd_b, wr and their valid flags.
- Natural sub-module: beta_scoreboard, containing the pending vector, the INFLIGHT counter, and the set/clear logic.
- The top level holds the state register, the hazard compare and the stall counter.

## Test plan

1. Reset with RST asserted mid-HELD -> all outputs 0, PENDING 0, IN_READY 1 after release.
2. Register op writing R3, followed by a register op reading R3, with ISSUE_READY held at 1 -> the second instruction stalls. WB_REG=3 at edge M -> it fires in cycle M+1, and STALL_CYCLES equals the number of stall cycles.
3. Five independent literal ops writing R1..R5 with no writeback, MAX_INFLIGHT=4 -> four fire, the fifth stalls with INFLIGHT=4. Any WB for one of R1..R4 -> the fifth fires.
4. Instruction writing R31 -> PENDING stays 0, INFLIGHT stays 0, and a following reader of R31 fires without stall.
5. Same-edge fire writing R7 plus WB_VALID for pending R2 -> PENDING[7]=1, PENDING[2]=0, INFLIGHT unchanged. WB for non-pending R9 -> no change.
6. FLUSH while HELD and stalled -> ISSUE_VALID 0 that cycle, state EMPTY next cycle, PENDING preserved, and IN_READY 0 during the FLUSH cycle.
